periph_csb_bridge: RTL and testbench

Parametrised HWPE-peripheral-to-NVDLA-CSB bridge for the hwpe_nvdla control path. It adds four things: CSB-ID window checking, byte-enable partial writes via read-modify-write (RMW), a response watchdog with error completion, and configurable address slicing and posting mode. There is one transaction in flight at a time. Periph gnt is issued only when the completion is known, and r_valid follows one cycle later.

---
 rtl/periph_csb_pkg.sv | 23 ++
 rtl/periph_csb_intf.sv | 29 ++
 rtl/periph_csb_bridge_watchdog.sv | 26 ++
 rtl/periph_csb_bridge.sv | 147 ++++++++++++++
 tb/tb_periph_csb_bridge.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/periph_csb_pkg.sv
// periph_csb_pkg: shared types and helpers for the periph-to-CSB bridge.
package periph_csb_pkg;

    typedef enum logic [2:0] {
        IDLE, CMD_RD, WAIT_RD, CMD_RMW_RD, WAIT_RMW_RD, CMD_WR, WAIT_WR, DONE
    } state_e;

    typedef enum logic [2:0] {MISS, NOP, RD, WR_FULL, WR_PART} req_class_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [31:0] merge_bytes(input logic [3:0] be, input logic [31:0] wdata,
                                                 input logic [31:0] rdata);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        return m;
    endfunction

    function automatic req_class_e classify(input logic miss, input logic wen, input logic [3:0] be);
        return miss ? MISS : wen ? RD : be == 4'h0 ? NOP : be == 4'hF ? WR_FULL : WR_PART;
    endfunction

endpackage

// File: rtl/periph_csb_intf.sv
// periph_csb_intf: HWPE peripheral port and NVDLA CSB port bundles.
interface hwpe_ctrl_intf_periph #(parameter int unsigned ID_WIDTH = 8);
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic                gnt;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;
    modport master(output req, add, wen, be, data, id, input gnt, r_data, r_valid, r_id);
    modport slave(input req, add, wen, be, data, id, output gnt, r_data, r_valid, r_id);
endinterface

interface nvdla_csb_intf;
    logic        valid;
    logic        ready;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic        write;
    logic        nposted;
    logic        r_valid;
    logic [31:0] r_data;
    logic        wr_complete;
    modport master(output valid, addr, wdat, write, nposted, input ready, r_valid, r_data, wr_complete);
    modport slave(input valid, addr, wdat, write, nposted, output ready, r_valid, r_data, wr_complete);
endinterface

// File: rtl/periph_csb_bridge_watchdog.sv
// csb_watchdog: counts cycles spent waiting for a CSB response.
module csb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = clear ? '0 : en ? cnt_q + 1'b1 : cnt_q;
        expired = en && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/periph_csb_bridge.sv
// periph_csb_bridge: single-outstanding HWPE periph to NVDLA CSB bridge with
// ID window check, byte-enable RMW, response watchdog and posting mode.
module periph_csb_bridge
    import periph_csb_pkg::*;
#(
    parameter int unsigned ID_WIDTH       = 8,
    parameter logic [15:0] CSB_ID         = 16'h0000,
    parameter bit          CHECK_ID       = 1'b1,
    parameter int unsigned ADDR_LSB       = 2,
    parameter bit          NPOSTED        = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    hwpe_ctrl_intf_periph.slave  periph,
    nvdla_csb_intf.master        csb,
    output logic                 err_o,
    output logic [15:0]          err_cnt_o,
    output logic                 busy_o
);

    state_e              state_q, state_d;
    logic [15:0]         addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         data_q, data_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                err_flag_q, err_flag_d;
    logic                r_valid_q, r_valid_d;
    logic [31:0]         r_data_q, r_data_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic                err_q, err_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                csb_valid, wd_clear, wd_en, wd_expired, rsp;
    req_class_e          cls;

    csb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clk), .rst(rst), .clear(wd_clear), .en(wd_en), .expired(wd_expired)
    );

    assign cls = classify(CHECK_ID && periph.add[31:16] != CSB_ID, periph.wen, periph.be);
    assign rsp = state_q == WAIT_WR ? csb.wr_complete : csb.r_valid;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        be_d       = be_q;
        data_d     = data_q;
        id_d       = id_q;
        err_flag_d = err_flag_q;
        r_valid_d  = 1'b0;
        r_data_d   = r_data_q;
        r_id_d     = r_id_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        csb_valid  = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;
        case (state_q)
            IDLE: if (periph.req) begin
                addr_d     = periph.add[ADDR_LSB +: 16];
                wen_d      = periph.wen;
                be_d       = periph.be;
                data_d     = periph.data;
                id_d       = periph.id;
                err_flag_d = cls == MISS;
                state_d    = (cls == MISS || cls == NOP) ? DONE : cls == RD ? CMD_RD :
                             cls == WR_FULL ? CMD_WR : CMD_RMW_RD;
            end
            CMD_RD, CMD_RMW_RD, CMD_WR: begin
                csb_valid = 1'b1;
                if (csb.ready) begin
                    wd_clear = 1'b1;
                    state_d  = state_q == CMD_RD ? WAIT_RD : state_q == CMD_RMW_RD ? WAIT_RMW_RD :
                               NPOSTED ? WAIT_WR : DONE;
                end
            end
            WAIT_RD, WAIT_RMW_RD, WAIT_WR: begin
                wd_en = 1'b1;
                // A response in the expiry cycle still wins over the timeout.
                if (rsp) begin
                    data_d  = state_q == WAIT_RMW_RD ? merge_bytes(be_q, data_q, csb.r_data) :
                              state_q == WAIT_RD ? csb.r_data : data_q;
                    state_d = state_q == WAIT_RMW_RD ? CMD_WR : DONE;
                end else if (wd_expired) begin
                    err_flag_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                r_valid_d = 1'b1;
                r_data_d  = err_flag_q ? ERR_DATA : wen_q ? data_q : '0;
                r_id_d    = id_q;
                err_d     = err_flag_q;
                err_cnt_d = (err_flag_q && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            be_q       <= '0;
            data_q     <= '0;
            id_q       <= '0;
            err_flag_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_id_q     <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            be_q       <= be_d;
            data_q     <= data_d;
            id_q       <= id_d;
            err_flag_q <= err_flag_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_id_q     <= r_id_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign periph.gnt     = !rst && state_q == DONE;
    assign periph.r_valid = r_valid_q;
    assign periph.r_data  = r_data_q;
    assign periph.r_id    = r_id_q;
    assign csb.valid      = !rst && csb_valid;
    assign csb.addr       = addr_q;
    assign csb.wdat       = data_q;
    assign csb.write      = state_q == CMD_WR;
    assign csb.nposted    = NPOSTED;
    assign err_o          = err_q;
    assign err_cnt_o      = err_cnt_q;
    assign busy_o         = state_q != IDLE;

endmodule

// File: tb/tb_periph_csb_bridge.sv
// tb_periph_csb_bridge: cycle-timeline model of two bridges (posted / non-posted writes).
module tb_periph_csb_bridge;

    localparam int N = 130;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic err_a, err_b, busy_a, busy_b;
    logic [15:0] ecnt_a, ecnt_b;
    int checks = 0;
    int errors = 0;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(8)) pa();
    hwpe_ctrl_intf_periph #(.ID_WIDTH(8)) pb();
    nvdla_csb_intf ca();
    nvdla_csb_intf cb();

    periph_csb_bridge #(.ID_WIDTH(8), .CSB_ID(16'h0000), .CHECK_ID(1'b1), .ADDR_LSB(2),
                        .NPOSTED(1'b1), .TIMEOUT_CYCLES(T), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .rst(rst_a), .periph(pa), .csb(ca),
        .err_o(err_a), .err_cnt_o(ecnt_a), .busy_o(busy_a)
    );

    periph_csb_bridge #(.ID_WIDTH(8), .CSB_ID(16'h0000), .CHECK_ID(1'b1), .ADDR_LSB(2),
                        .NPOSTED(1'b0), .TIMEOUT_CYCLES(T), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst(rst_b), .periph(pb), .csb(cb),
        .err_o(err_b), .err_cnt_o(ecnt_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    // Stimulus per instance per cycle.
    bit        drv_rst[2][N], drv_req[2][N], drv_wen[2][N], drv_ready[2][N], drv_rv[2][N], drv_wrc[2][N];
    bit [31:0] drv_add[2][N], drv_data[2][N], drv_rdata[2][N];
    bit [3:0]  drv_be[2][N];
    bit [7:0]  drv_id[2][N];
    // Expected outputs per instance per cycle.
    bit        exp_gnt[2][N], exp_rv[2][N], exp_err[2][N], exp_busy[2][N], exp_cv[2][N], exp_cw[2][N], err_ev[2][N];
    bit [31:0] exp_rdata[2][N], exp_cwdat[2][N];
    bit [15:0] exp_caddr[2][N], exp_ecnt[2][N];
    bit [7:0]  exp_rid[2][N];

    task automatic chk(input string name, input int u, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, u, c, act, exp);
        end
    endtask

    task automatic expect_cmd(input int u, input int p, input int h, input int lim, input bit [15:0] a,
                              input bit w, input bit [31:0] wd);
        for (int c = p; c <= h && c < lim; c++) begin
            exp_cv[u][c]    = 1'b1;
            exp_caddr[u][c] = a;
            exp_cw[u][c]    = w;
            exp_cwdat[u][c] = wd;
        end
    endtask

    // rd*: cycles valid waits before ready; rs*: cycles after handshake until the
    // response (0 = never). dut1 completes writes on handshake. abort: reset cycle.
    task automatic sched(input int u, input int t0, input bit [31:0] add, input bit wen, input bit [3:0] be,
                         input bit [31:0] data, input bit [7:0] id, input int rd1, input int rs1,
                         input bit [31:0] rdat, input int rd2, input int rs2, input int abort, output int done);
        bit err, full;
        bit [31:0] merged;
        bit [15:0] ca16;
        int h, lim;
        lim  = abort > 0 ? abort : N;
        ca16 = add[17:2];
        full = !wen && be == 4'hF;
        err  = 1'b0;
        if (add[31:16] != 16'h0000) begin
            err  = 1'b1;
            done = t0 + 1;
        end else if (!wen && be == 4'h0) begin
            done = t0 + 1;
        end else begin
            h = t0 + 1 + rd1;
            expect_cmd(u, t0 + 1, h, lim, ca16, full, data);
            drv_ready[u][h] = 1'b1;
            if (full && u == 1) done = h + 1;
            else begin
                if (rs1 > 0 && full) drv_wrc[u][h + rs1] = 1'b1;
                if (rs1 > 0 && !full) begin
                    drv_rv[u][h + rs1]    = 1'b1;
                    drv_rdata[u][h + rs1] = rdat;
                end
                err  = rs1 == 0 || rs1 > T;
                done = err ? h + T + 1 : h + rs1 + 1;
                if (!wen && !full && !err) begin
                    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? data[8*i +: 8] : rdat[8*i +: 8];
                    h = done + rd2;
                    expect_cmd(u, done, h, lim, ca16, 1'b1, merged);
                    drv_ready[u][h] = 1'b1;
                    if (u == 1) done = h + 1;
                    else begin
                        if (rs2 > 0) drv_wrc[u][h + rs2] = 1'b1;
                        err  = rs2 == 0 || rs2 > T;
                        done = err ? h + T + 1 : h + rs2 + 1;
                    end
                end
            end
        end
        for (int c = t0; c <= done && c < lim; c++) begin
            drv_req[u][c]  = 1'b1;
            drv_add[u][c]  = add;
            drv_wen[u][c]  = wen;
            drv_be[u][c]   = be;
            drv_data[u][c] = data;
            drv_id[u][c]   = id;
        end
        for (int c = t0 + 1; c <= done && c <= lim; c++) exp_busy[u][c] = 1'b1;
        if (done < lim) begin
            exp_gnt[u][done]       = 1'b1;
            exp_rv[u][done + 1]    = 1'b1;
            exp_rid[u][done + 1]   = id;
            exp_err[u][done + 1]   = err;
            exp_rdata[u][done + 1] = err ? 32'hDEAD_BEEF : wen ? rdat : 32'h0;
            err_ev[u][done]        = err;
        end
        if (abort > 0) drv_rst[u][abort] = 1'b1;
    endtask

    task automatic cmp(input int u, input int c, input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic [7:0] rid, input logic err, input logic [15:0] ecnt, input logic busy,
                       input logic cv, input logic [15:0] caddr, input logic cw, input logic [31:0] cwdat,
                       input logic np);
        chk("gnt", u, c, gnt, exp_gnt[u][c]);
        chk("r_valid", u, c, rv, exp_rv[u][c]);
        chk("err_o", u, c, err, exp_err[u][c]);
        chk("err_cnt", u, c, ecnt, exp_ecnt[u][c]);
        chk("busy", u, c, busy, exp_busy[u][c]);
        chk("csb_valid", u, c, cv, exp_cv[u][c]);
        if (exp_rv[u][c]) begin
            chk("r_data", u, c, rdata, exp_rdata[u][c]);
            chk("r_id", u, c, rid, exp_rid[u][c]);
        end
        if (exp_cv[u][c]) begin
            chk("csb_addr", u, c, caddr, exp_caddr[u][c]);
            chk("csb_write", u, c, cw, exp_cw[u][c]);
            chk("csb_nposted", u, c, np, u == 0);
            if (exp_cw[u][c]) chk("csb_wdat", u, c, cwdat, exp_cwdat[u][c]);
        end
    endtask

    initial begin
        int d_rd, d_rmw, d_miss, d_to, d_edge, d_np, d, cnt;
        for (int u = 0; u < 2; u++) for (int c = 0; c < 3; c++) drv_rst[u][c] = 1'b1;
        sched(0, 4,   32'h0000_0040, 1, 4'hF,    32'h0,         8'h11, 0, 1,  32'h1234_5678, 0, 0,  0,  d_rd);
        sched(0, 8,   32'h0000_0080, 0, 4'b0011, 32'hAAAA_BBBB, 8'h22, 1, 2,  32'h1111_2222, 0, 1,  0,  d_rmw);
        sched(0, 16,  32'h0001_0000, 1, 4'hF,    32'h0,         8'h33, 0, 1,  32'h0,         0, 0,  0,  d_miss);
        sched(0, 19,  32'h0000_0104, 1, 4'hF,    32'h0,         8'h44, 2, 20, 32'h0BAD_0BAD, 0, 0,  0,  d_to);
        sched(0, 44,  32'h0000_0208, 1, 4'hF,    32'h0,         8'h45, 0, T,  32'hCAFE_F00D, 0, 0,  0,  d_edge);
        sched(0, 63,  32'h0000_0300, 0, 4'h0,    32'hFFFF_FFFF, 8'h55, 0, 1,  32'h0,         0, 0,  0,  d);
        sched(0, 65,  32'h0000_0013, 0, 4'hF,    32'h0BAD_F00D, 8'h66, 0, 3,  32'h0,         0, 0,  0,  d);
        sched(0, 71,  32'h0000_0020, 0, 4'hF,    32'h0102_0304, 8'h77, 0, 0,  32'h0,         0, 0,  74, d);
        sched(0, 75,  32'h0000_0080, 1, 4'hF,    32'h0,         8'h88, 0, 1,  32'h55AA_55AA, 0, 0,  0,  d);
        sched(0, 80,  32'h0000_00C0, 0, 4'b1001, 32'h7856_3412, 8'h99, 0, 1,  32'hAABB_CCDD, 0, T,  0,  d);
        sched(0, 101, 32'h0000_00C4, 0, 4'b0010, 32'h0000_9900, 8'hAA, 0, 0,  32'h0,         0, 0,  0,  d);
        sched(1, 4,   32'h0000_0044, 0, 4'hF,    32'h1357_9BDF, 8'hB1, 5, 0,  32'h0,         0, 0,  0,  d_np);
        sched(1, 12,  32'h0000_0048, 0, 4'b0100, 32'h00EE_0000, 8'hB2, 0, 1,  32'h1122_3344, 2, 0,  0,  d);
        sched(1, 20,  32'h0000_004C, 1, 4'hF,    32'h0,         8'hB3, 0, 0,  32'h0,         0, 0,  0,  d);
        for (int u = 0; u < 2; u++) begin
            cnt = 0;
            for (int c = 0; c < N; c++) begin
                exp_ecnt[u][c] = 16'(cnt);
                if (drv_rst[u][c]) cnt = 0;
                else if (err_ev[u][c]) cnt++;
            end
        end
        chk("pin_rd_gnt", 0, 0, d_rd, 7);
        chk("pin_rmw_gnt", 0, 0, d_rmw, 15);
        chk("pin_miss_gnt", 0, 0, d_miss, 17);
        chk("pin_timeout_gnt", 0, 0, d_to, 39);
        chk("pin_edge_gnt", 0, 0, d_edge, 62);
        chk("pin_np_gnt", 1, 0, d_np, 11);
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            rst_a = drv_rst[0][c];       rst_b = drv_rst[1][c];
            pa.req = drv_req[0][c];      pb.req = drv_req[1][c];
            pa.add = drv_add[0][c];      pb.add = drv_add[1][c];
            pa.wen = drv_wen[0][c];      pb.wen = drv_wen[1][c];
            pa.be = drv_be[0][c];        pb.be = drv_be[1][c];
            pa.data = drv_data[0][c];    pb.data = drv_data[1][c];
            pa.id = drv_id[0][c];        pb.id = drv_id[1][c];
            ca.ready = drv_ready[0][c];  cb.ready = drv_ready[1][c];
            ca.r_valid = drv_rv[0][c];   cb.r_valid = drv_rv[1][c];
            ca.r_data = drv_rdata[0][c]; cb.r_data = drv_rdata[1][c];
            ca.wr_complete = drv_wrc[0][c];
            cb.wr_complete = drv_wrc[1][c];
            @(negedge clk);
            if (c >= 1) begin
                cmp(0, c, pa.gnt, pa.r_valid, pa.r_data, pa.r_id, err_a, ecnt_a, busy_a,
                    ca.valid, ca.addr, ca.write, ca.wdat, ca.nposted);
                cmp(1, c, pb.gnt, pb.r_valid, pb.r_data, pb.r_id, err_b, ecnt_b, busy_b,
                    cb.valid, cb.addr, cb.write, cb.wdat, cb.nposted);
            end
            if (c == 5)  chk("lit_rd_addr", 0, c, ca.addr, 32'h0010);
            if (c == 8)  chk("lit_rd_data", 0, c, pa.r_data, 32'h1234_5678);
            if (c == 13) chk("lit_rmw_wdat", 0, c, ca.wdat, 32'h1111_BBBB);
            if (c == 18) chk("lit_miss_cnt", 0, c, ecnt_a, 16'd1);
            if (c == 40) chk("lit_to_data", 0, c, pa.r_data, 32'hDEAD_BEEF);
            if (c == 63) chk("lit_edge_data", 0, c, pa.r_data, 32'hCAFE_F00D);
            if (c == 75) chk("lit_rst_busy", 0, c, busy_a, 1'b0);
            if (c == 10) chk("lit_np_wdat", 1, c, cb.wdat, 32'h1357_9BDF);
            if (c == 11) chk("lit_np_gnt", 1, c, pb.gnt, 1'b1);
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
